// File: rtl/vc_qspi_pkg.sv
// Shared QSPI definitions: command opcodes, responder state encoding and command decode.
// Used by both the responder and the QSPI initiator.
package vc_qspi_pkg;

    localparam logic [7:0] CMD_QREAD  = 8'hEB;
    localparam logic [7:0] CMD_QWRITE = 8'h38;

    // Bus cycle index of the last address nibble (2 command + 6 address nibbles)
    localparam int HDR_LAST = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } qspi_state_e;

    // State that follows the header for a given opcode
    function automatic qspi_state_e decode_cmd(input logic [7:0] cmd);
        case (cmd)
            CMD_QREAD:  return ST_DUMMY;
            CMD_QWRITE: return ST_WDATA;
            default:    return ST_IGNORE;
        endcase
    endfunction

endpackage

// File: rtl/qspi_resp_mem.sv
// DEPTH x 8 byte store: one bus read/write port and one backdoor read/write port,
// both with synchronous (registered) read data.
module qspi_resp_mem #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     bus_we_i,
    input  logic [$clog2(DEPTH)-1:0] bus_addr_i,
    input  logic [7:0]               bus_wdata_i,
    output logic [7:0]               bus_rdata_o,
    input  logic                     bd_we_i,
    input  logic [$clog2(DEPTH)-1:0] bd_addr_i,
    input  logic [7:0]               bd_wdata_i,
    output logic [7:0]               bd_rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] bus_rdata_q;
    logic [7:0] bd_rdata_q;

    // NOTE: the array has no reset on purpose; contents must survive reset and
    // a reset loop over every entry would also stop it mapping onto a RAM macro.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking writes; when both ports hit one address the later
        // assignment is the one that lands, so the bus write is placed last.
        if (bd_we_i) begin
            mem_q[bd_addr_i] <= bd_wdata_i;
        end
        if (bus_we_i) begin
            mem_q[bus_addr_i] <= bus_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        bus_rdata_q <= mem_q[bus_addr_i];
    end

    // Backdoor read bypasses a write landing at the same edge so it is never stale
    always_ff @(posedge clk) begin
        if (bus_we_i && (bus_addr_i == bd_addr_i)) begin
            bd_rdata_q <= bus_wdata_i;
        end else if (bd_we_i) begin
            bd_rdata_q <= bd_wdata_i;
        end else begin
            bd_rdata_q <= mem_q[bd_addr_i];
        end
    end

    assign bus_rdata_o = bus_rdata_q;
    assign bd_rdata_o  = bd_rdata_q;

endmodule

// File: rtl/qspi_responder.sv
// Quad-SPI memory responder clocked directly by the bus clock: command 0xEB reads,
// 0x38 writes, anything else is ignored until chip select is released.
module qspi_responder
    import vc_qspi_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int DUMMY = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cs_n,
    input  logic [3:0]               dq_in,
    output logic [3:0]               dq_out,
    output logic [3:0]               dq_oe,
    input  logic                     bd_we,
    input  logic [$clog2(DEPTH)-1:0] bd_addr,
    input  logic [7:0]               bd_wdata,
    output logic [7:0]               bd_rdata
);

    localparam int         AW         = $clog2(DEPTH);
    localparam logic [4:0] DUMMY_LAST = 5'(HDR_LAST + DUMMY);

    qspi_state_e   state_q;
    logic [4:0]    cnt_q;
    logic [7:0]    cmd_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;
    logic [3:0]    wbuf_q;
    logic          phase_q;
    logic          armed_q;
    logic [3:0]    dq_out_q;
    logic [3:0]    dq_oe_q;

    logic          bus_we;
    logic [7:0]    bus_wdata;
    logic [AW-1:0] bus_addr;
    logic [7:0]    rdata;
    logic [AW+3:0] addr_shift;

    // The read port is addressed with addr_d, so rdata always holds the byte at
    // addr_q; a burst advances without stalls, wrap included.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        addr_d     = addr_q;
        bus_we     = 1'b0;
        bus_wdata  = {wbuf_q, dq_in};
        addr_shift = {addr_q, dq_in};
        if (!reset && !cs_n) begin
            case (state_q)
                ST_ADDR:  addr_d = addr_shift[AW-1:0];
                ST_RDATA: begin
                    if (phase_q) begin
                        addr_d = addr_q + AW'(1);
                    end
                end
                ST_WDATA: begin
                    if (phase_q) begin
                        addr_d = addr_q + AW'(1);
                        bus_we = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        bus_addr = bus_we ? addr_q : addr_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cmd_q    <= '0;
            addr_q   <= '0;
            wbuf_q   <= '0;
            phase_q  <= 1'b0;
            armed_q  <= 1'b0;
            dq_out_q <= '0;
            dq_oe_q  <= '0;
        end else begin
            addr_q <= addr_d;
            if (cs_n) begin
                state_q  <= ST_IDLE;
                cnt_q    <= '0;
                phase_q  <= 1'b0;
                armed_q  <= 1'b1;
                dq_out_q <= '0;
                dq_oe_q  <= '0;
            end else begin
                case (state_q)
                    // armed_q holds off a transaction that was already running across reset
                    ST_IDLE: begin
                        if (armed_q) begin
                            cmd_q[7:4] <= dq_in;
                            cnt_q      <= 5'd1;
                            state_q    <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        cmd_q[3:0] <= dq_in;
                        cnt_q      <= 5'd2;
                        state_q    <= (decode_cmd({cmd_q[7:4], dq_in}) == ST_IGNORE)
                                      ? ST_IGNORE : ST_ADDR;
                    end
                    ST_ADDR: begin
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'(HDR_LAST)) begin
                            state_q <= decode_cmd(cmd_q);
                            phase_q <= 1'b0;
                        end
                    end
                    ST_DUMMY: begin
                        if (cnt_q == DUMMY_LAST) begin
                            state_q  <= ST_RDATA;
                            dq_oe_q  <= 4'hF;
                            dq_out_q <= rdata[7:4];
                            phase_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                    ST_RDATA: begin
                        dq_out_q <= phase_q ? rdata[3:0] : rdata[7:4];
                        phase_q  <= ~phase_q;
                    end
                    ST_WDATA: begin
                        if (!phase_q) begin
                            wbuf_q <= dq_in;
                        end
                        phase_q <= ~phase_q;
                    end
                    ST_IGNORE: ;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    qspi_resp_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk        (clk),
        .bus_we_i   (bus_we),
        .bus_addr_i (bus_addr),
        .bus_wdata_i(bus_wdata),
        .bus_rdata_o(rdata),
        .bd_we_i    (bd_we),
        .bd_addr_i  (bd_addr),
        .bd_wdata_i (bd_wdata),
        .bd_rdata_o (bd_rdata)
    );

    assign dq_out = dq_out_q;
    assign dq_oe  = dq_oe_q;

endmodule

// File: tb/tb_qspi_responder.sv
// Directed scoreboard bench for qspi_responder: quad reads/writes, wrap, partial byte,
// ignored command, reset mid-read and same-cycle bus/backdoor write collision.
module tb_qspi_responder;

    localparam int DEPTH = 256;
    localparam int DUMMY = 6;
    localparam int AW    = 8;

    logic          clk;
    logic          reset;
    logic          cs_n;
    logic [3:0]    dq_in;
    logic [3:0]    dq_out;
    logic [3:0]    dq_oe;
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [7:0]    bd_wdata;
    logic [7:0]    bd_rdata;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [7:0] model [DEPTH];
    logic [3:0] exp_nib_q [$];
    logic [7:0] exp_bd_q [$];
    logic [3:0] obs_out;
    logic [3:0] obs_oe;

    qspi_responder #(
        .DEPTH(DEPTH),
        .DUMMY(DUMMY)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cs_n    (cs_n),
        .dq_in   (dq_in),
        .dq_out  (dq_out),
        .dq_oe   (dq_oe),
        .bd_we   (bd_we),
        .bd_addr (bd_addr),
        .bd_wdata(bd_wdata),
        .bd_rdata(bd_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive mid-cycle, capture what the upcoming edge will sample
    task automatic send_nib(input logic [3:0] n);
        @(negedge clk);
        cs_n    = 1'b0;
        dq_in   = n;
        obs_out = dq_out;
        obs_oe  = dq_oe;
        @(posedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
        logic [31:0] w;
        w = {cmd, a};
        for (int i = 0; i < 8; i++) begin
            send_nib(w[31:28]);
            w = w << 4;
            check("hdr_oe", {4'h0, obs_oe}, 8'h00);
        end
    endtask

    task automatic end_txn();
        @(negedge clk);
        cs_n  = 1'b1;
        dq_in = 4'h0;
        @(posedge clk);
        @(negedge clk);
        check("end_oe", {4'h0, dq_oe}, 8'h00);
    endtask

    task automatic qread(input logic [23:0] a, input int nbytes);
        logic [AW-1:0] p;
        logic [3:0]    e;
        p = a[AW-1:0];
        for (int b = 0; b < nbytes; b++) begin
            exp_nib_q.push_back(model[p][7:4]);
            exp_nib_q.push_back(model[p][3:0]);
            p = p + 8'd1;
        end
        send_hdr(8'hEB, a);
        for (int d = 0; d < DUMMY; d++) begin
            send_nib(4'($urandom_range(15)));
            check("dummy_oe", {4'h0, obs_oe}, 8'h00);
        end
        for (int k = 0; k < 2 * nbytes; k++) begin
            send_nib(4'($urandom_range(15)));
            e = exp_nib_q.pop_front();
            check("rd_oe", {4'h0, obs_oe}, 8'h0F);
            check("rd_nib", {4'h0, obs_out}, {4'h0, e});
        end
        end_txn();
    endtask

    task automatic qwrite(input logic [23:0] a, input logic [31:0] data, input int nn);
        logic [AW-1:0] p;
        logic [31:0]   d;
        logic [3:0]    hi;
        p  = a[AW-1:0];
        d  = data;
        hi = 4'h0;
        send_hdr(8'h38, a);
        for (int i = 0; i < nn; i++) begin
            send_nib(d[31:28]);
            check("wr_oe", {4'h0, obs_oe}, 8'h00);
            if (i % 2 == 1) begin
                model[p] = {hi, d[31:28]};
                p = p + 8'd1;
            end else begin
                hi = d[31:28];
            end
            d = d << 4;
        end
        end_txn();
    endtask

    task automatic bd_load(input logic [AW-1:0] a, input logic [7:0] v);
        @(negedge clk);
        bd_we    = 1'b1;
        bd_addr  = a;
        bd_wdata = v;
        model[a] = v;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    task automatic bd_check(input logic [AW-1:0] a);
        @(negedge clk);
        bd_addr = a;
        exp_bd_q.push_back(model[a]);
        @(posedge clk);
        @(negedge clk);
        check("bd_rd", bd_rdata, exp_bd_q.pop_front());
    endtask

    initial begin
        reset    = 1'b1;
        cs_n     = 1'b1;
        dq_in    = 4'h0;
        bd_we    = 1'b0;
        bd_addr  = '0;
        bd_wdata = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_oe", {4'h0, dq_oe}, 8'h00);
        check("rst_out", {4'h0, dq_out}, 8'h00);
        reset = 1'b0;

        bd_load(8'h10, 8'hA5);
        bd_load(8'h11, 8'h3C);
        bd_load(8'h12, 8'h0F);
        bd_load(8'h13, 8'hF0);
        bd_load(8'h21, 8'h99);
        bd_load(8'h01, 8'h5A);
        bd_load(8'h40, 8'h00);

        // Basic quad read: A,5,3,C,0,F,F,0 from cycle 14
        qread(24'h000010, 4);

        // Quad write across the top of memory
        qwrite(24'h0000FE, 32'h1122_3300, 6);
        bd_check(8'hFE);
        bd_check(8'hFF);
        bd_check(8'h00);

        // Burst read across the wrap
        qread(24'h0000FF, 3);

        // Partial trailing nibble is discarded
        qwrite(24'h000020, 32'h4560_0000, 3);
        bd_check(8'h20);
        bd_check(8'h21);

        // Unknown command 0x9F followed by 20 nibbles
        send_nib(4'h9);
        check("ign_oe", {4'h0, obs_oe}, 8'h00);
        send_nib(4'hF);
        check("ign_oe", {4'h0, obs_oe}, 8'h00);
        for (int i = 0; i < 20; i++) begin
            send_nib((i == 4) ? 4'h1 : ((i < 6) ? 4'h0 : 4'hD));
            check("ign_oe", {4'h0, obs_oe}, 8'h00);
        end
        end_txn();
        for (int i = 0; i < 4; i++) begin
            bd_check(AW'(8'h10 + i));
        end
        qread(24'h000010, 4);

        // Reset at cycle 10 of a read with cs_n held low, then a fresh header without cs_n high
        send_hdr(8'hEB, 24'h000010);
        send_nib(4'h0);
        check("pre_rst_oe", {4'h0, obs_oe}, 8'h00);
        send_nib(4'h0);
        check("pre_rst_oe", {4'h0, obs_oe}, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        dq_in = 4'hE;
        check("rst_mid_oe", {4'h0, dq_oe}, 8'h00);
        check("rst_mid_out", {4'h0, dq_out}, 8'h00);
        @(posedge clk);
        for (int i = 0; i < 23; i++) begin
            send_nib((i == 0) ? 4'hB : ((i == 5) ? 4'h1 : 4'h0));
            check("no_resp_oe", {4'h0, obs_oe}, 8'h00);
        end
        end_txn();
        qread(24'h000010, 4);

        // Upper address bits beyond the memory size are ignored
        qread(24'hABCD12, 2);

        // Same-edge bus write (77) and backdoor write (88) to 0x40
        send_hdr(8'h38, 24'h000040);
        send_nib(4'h7);
        check("coll_oe", {4'h0, obs_oe}, 8'h00);
        @(negedge clk);
        dq_in    = 4'h7;
        bd_we    = 1'b1;
        bd_addr  = 8'h40;
        bd_wdata = 8'h88;
        model[8'h40] = 8'h77;
        exp_bd_q.push_back(8'h77);
        @(posedge clk);
        @(negedge clk);
        bd_we = 1'b0;
        cs_n  = 1'b1;
        check("coll_bypass", bd_rdata, exp_bd_q.pop_front());
        @(posedge clk);
        bd_check(8'h40);
        bd_check(8'h41);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
